prog_rom: RTL

Parametrised, loadable instruction memory for the processor's fetch stage. It is the successor to the fixed 7×3-bit instruction ROM. Contents are streamed in through a valid/ready load port after reset or on demand. Fetches are then served with one-cycle registered latency, a valid strobe and an out-of-range error flag.

---
 rtl/prog_rom_pkg.sv | 14 +
 rtl/prog_rom_if.sv | 32 +++
 rtl/rom_array.sv | 37 +++
 rtl/prog_rom.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/prog_rom_pkg.sv
// rtl/prog_rom_pkg.sv - shared types and default sizes for the loadable program memory
package prog_rom_pkg;

  localparam int ROM_DATA_W = 3;
  localparam int ROM_ADDR_W = 3;
  localparam int ROM_DEPTH  = 7;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_LOADING = 2'd1,
    ST_LOADED  = 2'd2
  } rom_state_t;

endpackage

// File: rtl/prog_rom_if.sv
// rtl/prog_rom_if.sv - load stream and fetch port bundle of the program memory
interface prog_rom_if
  import prog_rom_pkg::*;
#(
  parameter int DATA_W = ROM_DATA_W,
  parameter int ADDR_W = ROM_ADDR_W
) ();

  logic              load_start;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_ready;
  logic              load_done;
  logic              loaded;
  logic              enable;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              fetch_err;
  logic              not_ready;

  modport master (
    output load_start, load_valid, load_data, enable, addr,
    input  load_ready, load_done, loaded, data_out, data_valid, fetch_err, not_ready
  );

  modport slave (
    input  load_start, load_valid, load_data, enable, addr,
    output load_ready, load_done, loaded, data_out, data_valid, fetch_err, not_ready
  );

endinterface

// File: rtl/rom_array.sv
// rtl/rom_array.sv - unreset storage with one synchronous write and one registered read port
module rom_array #(
  parameter int DATA_W = 3,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 7
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] rd_data_d;

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = mem[rd_addr];
    end
  end

  // No reset so the array can map onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/prog_rom.sv
// rtl/prog_rom.sv - loadable instruction memory: load FSM, pointer, range check, fetch outputs
module prog_rom
  import prog_rom_pkg::*;
#(
  parameter int DATA_W = ROM_DATA_W,
  parameter int ADDR_W = ROM_ADDR_W,
  parameter int DEPTH  = ROM_DEPTH
) (
  input  logic      clock,
  input  logic      reset_n,
  prog_rom_if.slave bus
);

  localparam logic [1:0] EMPTY   = ST_EMPTY;
  localparam logic [1:0] LOADING = ST_LOADING;
  localparam logic [1:0] LOADED  = ST_LOADED;

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W + 1)'(DEPTH);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              load_done_q, load_done_d;
  logic              data_valid_q, data_valid_d;
  logic              fetch_err_q, fetch_err_d;
  logic              not_ready_q, not_ready_d;
  logic              rd_ok_q, rd_ok_d;

  logic              wr_en;
  logic              rd_en;
  logic              in_range;
  logic [DATA_W-1:0] rd_data;

  assign in_range = ({1'b0, bus.addr} < DEPTH_C);

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    load_done_d  = 1'b0;
    wr_en        = 1'b0;
    rd_en        = 1'b0;
    data_valid_d = 1'b0;
    not_ready_d  = 1'b0;
    fetch_err_d  = fetch_err_q;
    rd_ok_d      = rd_ok_q;

    // Fetches only look at the current state, so a fetch alongside load_start in
    // LOADED still reads the old image (no writes happen in LOADED).
    if (bus.enable) begin
      if (state_q == LOADED) begin
        data_valid_d = 1'b1;
        if (in_range) begin
          rd_en       = 1'b1;
          rd_ok_d     = 1'b1;
          fetch_err_d = 1'b0;
        end else begin
          rd_ok_d     = 1'b0;
          fetch_err_d = 1'b1;
        end
      end else begin
        not_ready_d = 1'b1;
      end
    end

    case (state_q)
      EMPTY: begin
        if (bus.load_start) begin
          state_d = LOADING;
          ptr_d   = '0;
        end
      end
      LOADING: begin
        if (bus.load_start) begin
          ptr_d = '0;
        end else if (bus.load_valid) begin
          wr_en = 1'b1;
          if (ptr_q == LAST_PTR) begin
            state_d     = LOADED;
            load_done_d = 1'b1;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end
      end
      LOADED: begin
        if (bus.load_start) begin
          state_d = LOADING;
          ptr_d   = '0;
        end
      end
      default: begin
        state_d = EMPTY;
        ptr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= EMPTY;
      ptr_q        <= '0;
      load_done_q  <= 1'b0;
      data_valid_q <= 1'b0;
      fetch_err_q  <= 1'b0;
      not_ready_q  <= 1'b0;
      rd_ok_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      load_done_q  <= load_done_d;
      data_valid_q <= data_valid_d;
      fetch_err_q  <= fetch_err_d;
      not_ready_q  <= not_ready_d;
      rd_ok_q      <= rd_ok_d;
    end
  end

  rom_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk     (clock),
    .wr_en   (wr_en),
    .wr_addr (ptr_q),
    .wr_data (bus.load_data),
    .rd_en   (rd_en),
    .rd_addr (bus.addr),
    .rd_data (rd_data)
  );

  // rd_ok_q masks the unreset read register until a valid in-range fetch lands.
  assign bus.data_out   = rd_ok_q ? rd_data : '0;
  assign bus.data_valid = data_valid_q;
  assign bus.fetch_err  = fetch_err_q;
  assign bus.not_ready  = not_ready_q;
  assign bus.load_done  = load_done_q;
  assign bus.load_ready = (state_q == LOADING);
  assign bus.loaded     = (state_q == LOADED);

endmodule
